inst_encoder: RTL and testbench

//  Inverse of the immediate generator: packs opcode, register fields, funct bits and a 32-bit

---
 rtl/inst_enc_pkg.sv | 60 ++++++
 rtl/inst_encoder_if.sv | 39 +++
 rtl/inst_enc_pack.sv | 56 +++++
 rtl/inst_encoder.sv | 133 +++++++++++++
 tb/tb_inst_encoder.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Optional checking is enabled with the INST_ENC_CHECK_EN macro (see inst_enc_pack / inst_encoder).
package inst_enc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned ERRC_W = 2;

  // Instruction format codes; 5..7 are illegal
  localparam logic [FMT_W-1:0] FMT_I  = 3'd0;
  localparam logic [FMT_W-1:0] FMT_S  = 3'd1;
  localparam logic [FMT_W-1:0] FMT_SB = 3'd2;
  localparam logic [FMT_W-1:0] FMT_UJ = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U  = 3'd4;

  // Opcodes of the instructions the loader typically emits
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;

  // Error codes; a larger code has priority when several apply
  typedef enum logic [ERRC_W-1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // One encode request as seen by the packer
  typedef struct packed {
    logic [FMT_W-1:0] fmt;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [XLEN-1:0]  imm;
  } enc_req_t;

  // True when v, read as signed, is representable in a w-bit signed field
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned w);
    logic signed [XLEN-1:0] lim;
    lim = 32'sd1 <<< (w - 1);
    return ($signed(v) >= -lim) && ($signed(v) < lim);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder (loader side and imem write side).
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 14
);
  import inst_enc_pkg::*;

  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic                     in_valid;
  logic                     in_ready;
  logic [FMT_W-1:0]         in_fmt;
  logic [OPC_W-1:0]         in_opcode;
  logic [REG_W-1:0]         in_rd;
  logic [REG_W-1:0]         in_rs1;
  logic [REG_W-1:0]         in_rs2;
  logic [F3_W-1:0]          in_funct3;
  logic [XLEN-1:0]          in_imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_addr;
  logic [XLEN-1:0]          out_inst;
  logic                     err;
  logic [ERRC_W-1:0]        err_code;

  // Driver of requests and sink of encoded words
  modport master (
    output start, base_addr, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_inst, err, err_code
  );

  // The encoder itself
  modport slave (
    input  start, base_addr, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_inst, err, err_code
  );

endinterface

// File: rtl/inst_enc_pack.sv
// Combinational RV32I packer: places fields and immediate bits into one word.
// With INST_ENC_CHECK_EN defined it also reports range/alignment/format errors.
module inst_enc_pack
  import inst_enc_pkg::*;
(
  input  enc_req_t          req_i,
  output logic [XLEN-1:0]   inst_c_o,
  output logic [ERRC_W-1:0] code_c_o
);

  logic [XLEN-1:0] imm;
  assign imm = req_i.imm;

  // Scatter immediate bits into the format's slots; illegal formats pack as I
  always_comb begin : pack_word
    inst_c_o = '0;
    case (req_i.fmt)
      FMT_S:   inst_c_o = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm[4:0], req_i.opcode};
      FMT_SB:  inst_c_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                           imm[4:1], imm[11], req_i.opcode};
      FMT_UJ:  inst_c_o = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, req_i.opcode};
      FMT_U:   inst_c_o = {imm[19:0], req_i.rd, req_i.opcode};
      default: inst_c_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  // Highest applicable code wins: format, then alignment, then range
  always_comb begin : range_check
    code_c_o = ERR_NONE;
    case (req_i.fmt)
      FMT_I, FMT_S: begin
        if (!fits_signed(imm, 12)) code_c_o = ERR_RANGE;
      end
      FMT_SB: begin
        if (imm[0])                      code_c_o = ERR_ALIGN;
        else if (!fits_signed(imm, 13))  code_c_o = ERR_RANGE;
      end
      FMT_UJ: begin
        if (imm[0])                      code_c_o = ERR_ALIGN;
        else if (!fits_signed(imm, 21))  code_c_o = ERR_RANGE;
      end
      FMT_U: begin
        if (!fits_signed(imm, 20)) code_c_o = ERR_RANGE;
      end
      default: code_c_o = ERR_FMT;
    endcase
  end
`else
  // Without checking, high immediate bits are simply truncated away
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign code_c_o      = ERR_NONE;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder top: FSM, single output register and write-address counter.
// INST_ENC_CHECK_EN enables rejecting bad requests (err/err_code, ERR state).
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input logic           clk,
  input logic           rst_n,
  inst_encoder_if.slave bus
);

  localparam int unsigned ADDR_STEP = 4;

  state_e              state_q, state_d;
  logic                in_ready_c;
  logic                accept_c;
  logic                load_c;
  logic                bad_c;
  logic                out_fire_c;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   base_aligned_c;
  logic [XLEN-1:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0]     pack_inst_c;
  logic [ERRC_W-1:0]   pack_code_c;
  logic                err_q, err_d;
  logic [ERRC_W-1:0]   err_code_q, err_code_d;
  enc_req_t            req_c;
  logic                unused_base_lsb;

  // Gather the request fields into one payload
  always_comb begin : req_gather
    req_c        = '0;
    req_c.fmt    = bus.in_fmt;
    req_c.opcode = bus.in_opcode;
    req_c.rd     = bus.in_rd;
    req_c.rs1    = bus.in_rs1;
    req_c.rs2    = bus.in_rs2;
    req_c.funct3 = bus.in_funct3;
    req_c.imm    = bus.in_imm;
  end

  inst_enc_pack u_pack (
    .req_i    (req_c),
    .inst_c_o (pack_inst_c),
    .code_c_o (pack_code_c)
  );

`ifdef INST_ENC_CHECK_EN
  assign bad_c = (pack_code_c != ERR_NONE);
`else
  logic unused_code;
  assign unused_code = ^pack_code_c;
  assign bad_c       = 1'b0;
`endif

  // Word addresses are always 4-byte aligned
  assign base_aligned_c  = {bus.base_addr[ADDR_W-1:2], 2'b00};
  assign unused_base_lsb = ^bus.base_addr[1:0];

  // FSM state register
  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start always re-enters RUN, a rejected request parks in ERR
  always_comb begin : state_next
    state_d = state_q;
    if (bus.start)                 state_d = ST_RUN;
    else if (accept_c && bad_c)    state_d = ST_ERR;
  end

  // FSM outputs: handshake qualifiers for both sides of the output register
  always_comb begin : state_out
    in_ready_c = 1'b0;
    if (state_q == ST_RUN) in_ready_c = !out_valid_q || bus.out_ready;
    accept_c   = bus.in_valid && in_ready_c;
    load_c     = accept_c && !bad_c;
    out_fire_c = out_valid_q && bus.out_ready;
  end

  // Next values of the output register, address counter and error flags
  always_comb begin : dp_next
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_inst_d  = out_inst_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    if (load_c)                        out_valid_d = 1'b1;
    else if (bus.start || out_fire_c)  out_valid_d = 1'b0;

    if (bus.start)        out_addr_d = base_aligned_c;
    else if (out_fire_c)  out_addr_d = out_addr_q + ADDR_W'(ADDR_STEP);

    if (load_c) out_inst_d = pack_inst_c;

    if (bus.start) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else if (accept_c && bad_c) begin
      err_d      = 1'b1;
      err_code_d = pack_code_c;
    end
  end

  // Output register, address counter and sticky error
  always_ff @(posedge clk) begin : dp_reg
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_inst_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_inst_q  <= out_inst_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed steps plus a randomized scoreboard phase.
// Expected words are checked by decoding them with an immediate-generator model.
module tb_inst_encoder;
  import inst_enc_pkg::*;

  localparam int unsigned AW  = 14;
  localparam int unsigned AW4 = 4;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  req_t q[$];
  int   nout;
  logic [31:0] rbase;

  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(AW))  bus ();
  inst_encoder_if #(.ADDR_W(AW4)) bus4 ();

  inst_encoder #(.ADDR_W(AW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  inst_encoder #(.ADDR_W(AW4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic signed [31:0] t;
    t = $signed(v << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Immediate the decoder should recover (truncation to field width when unchecked)
  function automatic logic [31:0] exp_imm(input req_t r);
    case (r.fmt)
      FMT_SB:  return sext(r.imm, 13) & ~32'd1;
      FMT_UJ:  return sext(r.imm, 21) & ~32'd1;
      FMT_U:   return sext(r.imm, 20);
      default: return sext(r.imm, 12);
    endcase
  endfunction

  // Reference immediate generator
  function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] i);
    case (fmt)
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_SB:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_UJ:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      FMT_U:   return {{12{i[31]}}, i[31:12]};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic [3:0] field_use(input logic [2:0] fmt);
    // {rd, rs1, rs2, f3}
    case (fmt)
      FMT_S, FMT_SB: return 4'b0111;
      FMT_UJ, FMT_U: return 4'b1000;
      default:       return 4'b1101;
    endcase
  endfunction

  function automatic logic [24:0] inst_fields(input logic [2:0] fmt, input logic [31:0] i);
    logic [3:0]  u;
    logic [24:0] f;
    u = field_use(fmt);
    f = '0;
    f[24:18] = i[6:0];
    if (u[3]) f[17:13] = i[11:7];
    if (u[2]) f[12:8]  = i[19:15];
    if (u[1]) f[7:3]   = i[24:20];
    if (u[0]) f[2:0]   = i[14:12];
    return f;
  endfunction

  function automatic logic [24:0] req_fields(input req_t r);
    logic [3:0]  u;
    logic [24:0] f;
    u = field_use(r.fmt);
    f = '0;
    f[24:18] = r.op;
    if (u[3]) f[17:13] = r.rd;
    if (u[2]) f[12:8]  = r.rs1;
    if (u[1]) f[7:3]   = r.rs2;
    if (u[0]) f[2:0]   = r.f3;
    return f;
  endfunction

  function automatic req_t rand_req();
    req_t r;
`ifdef INST_ENC_CHECK_EN
    r.fmt = 3'($urandom_range(0, 4));
`else
    r.fmt = 3'($urandom_range(0, 7));
`endif
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: r.imm = sext($urandom, 21);
      default: begin
        case ($urandom_range(0, 7))
          0: r.imm = 32'd2047;
          1: r.imm = -32'd2048;
          2: r.imm = 32'd4094;
          3: r.imm = -32'd4096;
          4: r.imm = 32'd1048574;
          5: r.imm = -32'd1048576;
          6: r.imm = 32'd524287;
          default: r.imm = -32'd524288;
        endcase
      end
    endcase
`ifdef INST_ENC_CHECK_EN
    r.imm = exp_imm(r);
`endif
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.in_fmt    = r.fmt;
    bus.in_opcode = r.op;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_funct3 = r.f3;
    bus.in_imm    = r.imm;
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.imm = imm;
    return r;
  endfunction

  // Compare the word leaving the encoder against the scoreboard head
  task automatic pop_check();
    req_t e;
    logic [31:0] exp_addr;
    check("sb_size", 32'(q.size()), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      exp_addr = (rbase + 32'(nout) * 32'd4) % (32'd1 << AW);
      check("word_addr", 32'(bus.out_addr), exp_addr);
      check("word_imm", dec_imm(e.fmt, bus.out_inst), exp_imm(e));
      check("word_fields", 32'(inst_fields(e.fmt, bus.out_inst)), 32'(req_fields(e)));
      nout++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.base_addr = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_imm = '0;
    bus4.start = 1'b0; bus4.base_addr = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.in_fmt = FMT_I; bus4.in_opcode = OP_IMM; bus4.in_rd = 5'd3; bus4.in_rs1 = 5'd4;
    bus4.in_rs2 = '0; bus4.in_funct3 = '0; bus4.in_imm = 32'd5;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);

    // start base 0x100, addi x1, x0, -1
    rst_n = 1'b1;
    bus.start = 1'b1; bus.base_addr = 14'h100;
    @(negedge clk);
    bus.start = 1'b0;
    drive(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, -32'd1));
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1 check("run_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_addr", 32'(bus.out_addr), 32'h100);
    check("addi_inst", bus.out_inst, 32'hFFF00093);
    check("addi_roundtrip", dec_imm(FMT_I, bus.out_inst), -32'd1);

    // Stall 3 cycles with a beq waiting
    drive(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, -32'd4));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_addr", 32'(bus.out_addr), 32'h100);
      check("stall_inst", bus.out_inst, 32'hFFF00093);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 check("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("beq_addr", 32'(bus.out_addr), 32'h104);
    check("beq_inst", bus.out_inst, 32'hFE208EE3);
    check("beq_roundtrip", dec_imm(FMT_SB, bus.out_inst), -32'd4);

    // Back-to-back jal
    drive(mk(FMT_UJ, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048));
    #1 check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("jal_valid", 32'(bus.out_valid), 32'd1);
    check("jal_addr", 32'(bus.out_addr), 32'h108);
    check("jal_inst", bus.out_inst, 32'h001000EF);
    check("jal_roundtrip", dec_imm(FMT_UJ, bus.out_inst), 32'd2048);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_addr", 32'(bus.out_addr), 32'h10C);

    // Start while a word is held drops it and reloads the address
    drive(mk(FMT_U, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 32'h12345));
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lui_inst", bus.out_inst, 32'h123453B7);
    bus.start = 1'b1; bus.base_addr = 14'h202;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_drop_valid", 32'(bus.out_valid), 32'd0);
    check("start_reload_addr", 32'(bus.out_addr), 32'h200);

`ifdef INST_ENC_CHECK_EN
    // I imm out of range is consumed, flagged and blocks further input
    drive(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048));
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    check("range_err", 32'(bus.err), 32'd1);
    check("range_code", 32'(bus.err_code), 32'd1);
    check("range_no_word", 32'(bus.out_valid), 32'd0);
    check("range_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("restart_err", 32'(bus.err), 32'd0);
    check("restart_in_ready", 32'(bus.in_ready), 32'd1);
    // Odd and out-of-range branch offset: alignment code wins
    drive(mk(FMT_SB, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5001));
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("align_code", 32'(bus.err_code), 32'd2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive(mk(3'd6, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1));
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fmt_code", 32'(bus.err_code), 32'd3);
    check("fmt_no_word", 32'(bus.out_valid), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
`else
    // Illegal format with oversized imm encodes as I and raises nothing
    drive(mk(3'd7, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048));
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("illfmt_valid", 32'(bus.out_valid), 32'd1);
    check("illfmt_inst", bus.out_inst, 32'h80000093);
    check("illfmt_err", 32'(bus.err), 32'd0);
    check("illfmt_code", 32'(bus.err_code), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
`endif

    // Reset mid-stream discards the held word
    drive(mk(FMT_S, OP_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 32'd12));
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_addr", 32'(bus.out_addr), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1 check("midrst_idle", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Randomized stream with address wrap near the top of the space
    rbase = 32'h3FF0; nout = 0; q.delete();
    bus.start = 1'b1; bus.base_addr = 14'h3FF3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_t r;
      r = rand_req();
      drive(r);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      check("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
      if (bus.out_valid && bus.out_ready) pop_check();
      if (bus.in_valid && bus.in_ready) q.push_back(r);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      #1;
      if (bus.out_valid) pop_check();
      @(negedge clk);
    end
    check("rnd_drained", 32'(q.size()), 32'd0);
    check("rnd_err", 32'(bus.err), 32'd0);

    // Narrow address space: 0xC then wrap to 0x0
    bus4.start = 1'b1; bus4.base_addr = 4'hC;
    @(negedge clk);
    bus4.start = 1'b0; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    check("w4_first_valid", 32'(bus4.out_valid), 32'd1);
    check("w4_first_addr", 32'(bus4.out_addr), 32'hC);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("w4_wrap_addr", 32'(bus4.out_addr), 32'h0);
    @(negedge clk);
    check("w4_done_valid", 32'(bus4.out_valid), 32'd0);
    check("w4_next_addr", 32'(bus4.out_addr), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
